// File: rtl/board_editor_pkg.sv
// ---------------------------------------------------------------------------
// board_editor_pkg
// Shared board geometry and types for the board editor and the blocks that
// read the same board RAM.
//   BOARD_SIZE x BOARD_SIZE cells, row-major, WORD_SIZE cells per RAM word,
//   bit 0 of a word is its leftmost cell.
// Contents:
//   edit_op_t      - edit operation encoding carried on op_in
//   editor_state_t - board_editor controller states
//   apply_edit     - forms the new word for a single-cell edit
// ---------------------------------------------------------------------------
package board_editor_pkg;

  localparam int BOARD_SIZE     = 64;
  localparam int LOG_BOARD_SIZE = $clog2(BOARD_SIZE);
  localparam int WORD_SIZE      = 16;
  localparam int LOG_WORD_SIZE  = $clog2(WORD_SIZE);
  localparam int NUM_WORDS      = BOARD_SIZE * BOARD_SIZE / WORD_SIZE;
  localparam int LOG_MAX_ADDR   = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    OP_TOGGLE      = 2'd0,
    OP_SET         = 2'd1,
    OP_CLEAR_CELL  = 2'd2,
    OP_CLEAR_BOARD = 2'd3
  } edit_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_SWEEP = 3'd3,
    ST_DONE  = 3'd4
  } editor_state_t;

  // Only the addressed bit changes; every other cell of the word is kept.
  function automatic logic [WORD_SIZE-1:0] apply_edit(
    input edit_op_t                 op,
    input logic [WORD_SIZE-1:0]     word,
    input logic [LOG_WORD_SIZE-1:0] bit_idx
  );
    logic [WORD_SIZE-1:0] mask;
    logic [WORD_SIZE-1:0] result;
    mask          = '0;
    mask[bit_idx] = 1'b1;
    case (op)
      OP_TOGGLE:     result = word ^ mask;
      OP_SET:        result = word | mask;
      OP_CLEAR_CELL: result = word & ~mask;
      default:       result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/board_editor_cell_addr_map.sv
// ---------------------------------------------------------------------------
// cell_addr_map
// Combinational mapping of a board cell (x,y) to its RAM word address and
// bit position inside that word. Any block that packs or unpacks board words
// must use this so both ends agree on the layout.
// Ports:
//   x_in          - cell column
//   y_in          - cell row
//   word_addr_out - (y*BOARD_SIZE + x) >> LOG_WORD_SIZE, truncated
//   bit_idx_out   - x mod WORD_SIZE (bit 0 = leftmost cell of the word)
// ---------------------------------------------------------------------------
module cell_addr_map
  import board_editor_pkg::*;
(
  input  logic [LOG_BOARD_SIZE-1:0] x_in,
  input  logic [LOG_BOARD_SIZE-1:0] y_in,
  output logic [LOG_MAX_ADDR-1:0]   word_addr_out,
  output logic [LOG_WORD_SIZE-1:0]  bit_idx_out
);

  // With power-of-two sizes, y*BOARD_SIZE + x is just the concatenation {y,x}.
  // Since BOARD_SIZE >= WORD_SIZE, a word never spans two rows, so the bit
  // index comes straight from the low bits of x.
  always_comb begin
    word_addr_out = LOG_MAX_ADDR'({y_in, x_in} >> LOG_WORD_SIZE);
    bit_idx_out   = x_in[LOG_WORD_SIZE-1:0];
  end

endmodule

// File: rtl/board_editor.sv
// ---------------------------------------------------------------------------
// board_editor
// Write-side companion of the board renderer: applies user edits to the
// board RAM. Single-cell edits (toggle/set/clear) read-modify-write one
// word; a board clear sweeps zeros over every word.
// Ports:
//   clk_in       - system clock
//   rst_in       - synchronous active-high reset
//   start_in     - request strobe, sampled only while idle
//   op_in        - 0 TOGGLE, 1 SET, 2 CLEAR_CELL, 3 CLEAR_BOARD
//   cursor_x_in  - target cell column
//   cursor_y_in  - target cell row
//   data_r_in    - RAM read data, valid READ_LATENCY cycles after address
//   addr_r_out   - RAM read address
//   addr_w_out   - RAM write address
//   data_w_out   - RAM write data
//   we_out       - RAM write enable
//   busy_out     - high from accepted start until done
//   done_out     - one-cycle completion pulse
// ---------------------------------------------------------------------------
module board_editor
  import board_editor_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic [1:0]                op_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
  input  logic [WORD_SIZE-1:0]      data_r_in,
  output logic [LOG_MAX_ADDR-1:0]   addr_r_out,
  output logic [LOG_MAX_ADDR-1:0]   addr_w_out,
  output logic [WORD_SIZE-1:0]      data_w_out,
  output logic                      we_out,
  output logic                      busy_out,
  output logic                      done_out
);

  localparam int CNT_W = $clog2(READ_LATENCY + 2);
  localparam logic [LOG_MAX_ADDR-1:0] LAST_ADDR = LOG_MAX_ADDR'(NUM_WORDS - 1);

  editor_state_t              state_q,  state_d;
  edit_op_t                   op_q,     op_d;
  logic [LOG_WORD_SIZE-1:0]   bit_q,    bit_d;
  logic [CNT_W-1:0]           cnt_q,    cnt_d;
  logic [LOG_MAX_ADDR-1:0]    addr_r_q, addr_r_d;
  logic [LOG_MAX_ADDR-1:0]    addr_w_q, addr_w_d;
  logic [WORD_SIZE-1:0]       data_w_q, data_w_d;
  logic                       we_q,     we_d;
  logic                       busy_q,   busy_d;
  logic                       done_q,   done_d;

  logic [LOG_MAX_ADDR-1:0]    cursor_addr;
  logic [LOG_WORD_SIZE-1:0]   cursor_bit;
  logic                       read_last;

  // The cursor is mapped at request time; the request is then held as
  // {word address, bit index}, which fully stands in for the latched (x,y).
  cell_addr_map u_map (
    .x_in          (cursor_x_in),
    .y_in          (cursor_y_in),
    .word_addr_out (cursor_addr),
    .bit_idx_out   (cursor_bit)
  );

  // The address goes out at the start edge, so read data is first sampleable
  // READ_LATENCY+1 edges later; the READ state counts 0..READ_LATENCY and
  // captures on the final count.
  assign read_last = (state_q == ST_READ) && (cnt_q == CNT_W'(READ_LATENCY));

  // State and all output registers. Reset clears everything, which also
  // aborts any sweep in progress without a done pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_TOGGLE;
      bit_q    <= '0;
      cnt_q    <= '0;
      addr_r_q <= '0;
      addr_w_q <= '0;
      data_w_q <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      addr_r_q <= addr_r_d;
      addr_w_q <= addr_w_d;
      data_w_q <= data_w_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic. The sweep leaves on the terminal address compare,
  // before the counter could wrap back to zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = (edit_op_t'(op_in) == OP_CLEAR_BOARD) ? ST_SWEEP : ST_READ;
        end
      end
      ST_READ:  if (read_last) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_DONE;
      ST_SWEEP: if (addr_w_q == LAST_ADDR) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs. Addresses and data hold unless updated;
  // the strobes are decoded from the state being entered so they line up
  // with it exactly.
  always_comb begin
    op_d     = op_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    addr_r_d = addr_r_q;
    addr_w_d = addr_w_q;
    data_w_d = data_w_q;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          op_d  = edit_op_t'(op_in);
          cnt_d = '0;
          if (edit_op_t'(op_in) == OP_CLEAR_BOARD) begin
            addr_w_d = '0;
            data_w_d = '0;
          end else begin
            bit_d    = cursor_bit;
            addr_r_d = cursor_addr;
          end
        end
      end
      ST_READ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (read_last) begin
          addr_w_d = addr_r_q;
          data_w_d = apply_edit(op_q, data_r_in, bit_q);
        end
      end
      ST_SWEEP: begin
        if (addr_w_q != LAST_ADDR) addr_w_d = addr_w_q + LOG_MAX_ADDR'(1);
      end
      default: ;
    endcase

    we_d   = (state_d == ST_WRITE) || (state_d == ST_SWEEP);
    busy_d = (state_d == ST_READ) || (state_d == ST_WRITE) || (state_d == ST_SWEEP);
    done_d = (state_d == ST_DONE);
  end

  assign addr_r_out = addr_r_q;
  assign addr_w_out = addr_w_q;
  assign data_w_out = data_w_q;
  assign we_out     = we_q;
  assign busy_out   = busy_q;
  assign done_out   = done_q;

endmodule
